// File: rtl/poly2_sample_window_if.sv
// rtl/poly2_sample_window_if.sv - sample-in / window-out handshake bundle for poly2_sample_window
interface poly2_sample_window_if #(
   parameter int DATA_WIDTH = 16,
   parameter int PHASES     = 4
);
   localparam int PW = $clog2(PHASES);

   logic [DATA_WIDTH-1:0] data_i;
   logic                  valid_i;
   logic                  ready_o;
   logic [DATA_WIDTH-1:0] x0_o;
   logic [DATA_WIDTH-1:0] x1_o;
   logic [DATA_WIDTH-1:0] x2_o;
   logic [PW-1:0]         phase_o;
   logic                  last_o;
   logic                  valid_o;
   logic                  ready_i;
   logic                  primed_o;

   // block side
   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, x0_o, x1_o, x2_o, phase_o, last_o, valid_o, primed_o
   );

   // environment side: feeds samples upstream, consumes steps downstream
   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, x0_o, x1_o, x2_o, phase_o, last_o, valid_o, primed_o
   );
endinterface

// File: rtl/poly2_sample_window.sv
// rtl/poly2_sample_window.sv - 3-tap sliding window feeder issuing PHASES steps per window
module poly2_sample_window #(
   parameter int DATA_WIDTH = 16,
   parameter int PHASES     = 4
) (
   input  logic                  clk,
   input  logic                  rsth,
   input  logic                  clrh,
   poly2_sample_window_if.slave  bus
);
   localparam int          PW       = $clog2(PHASES);
   localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);

   typedef enum logic [1:0] {ST_FILL, ST_EMIT, ST_LOAD} state_e;

   state_e                state_q, state_d;
   logic [1:0]            fill_cnt_q, fill_cnt_d;
   logic [DATA_WIDTH-1:0] x0_q, x0_d;
   logic [DATA_WIDTH-1:0] x1_q, x1_d;
   logic [DATA_WIDTH-1:0] x2_q, x2_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic                  last_q, last_d;
   logic                  valid_q, valid_d;
   logic                  primed_q, primed_d;

   logic ready;
   logic accept;
   logic step;

   // ready depends on state alone so upstream never sees a combinational path from ready_i
   assign ready  = (state_q != ST_EMIT);
   assign accept = bus.valid_i & ready;
   assign step   = valid_q & bus.ready_i;

   // next-state and registered-output decode; clear wins over every handshake
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      phase_d    = phase_q;
      last_d     = last_q;
      valid_d    = valid_q;
      primed_d   = primed_q;

      if (clrh) begin
         state_d    = ST_FILL;
         fill_cnt_d = 2'd0;
         x0_d       = '0;
         x1_d       = '0;
         x2_d       = '0;
         phase_d    = '0;
         last_d     = 1'b0;
         valid_d    = 1'b0;
         primed_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_FILL: begin
               if (accept) begin
                  x2_d = x1_q;
                  x1_d = x0_q;
                  x0_d = bus.data_i;
                  if (fill_cnt_q == 2'd2) begin
                     fill_cnt_d = 2'd0;
                     primed_d   = 1'b1;
                     phase_d    = '0;
                     last_d     = 1'b0;
                     valid_d    = 1'b1;
                     state_d    = ST_EMIT;
                  end else begin
                     fill_cnt_d = fill_cnt_q + 2'd1;
                  end
               end
            end
            ST_EMIT: begin
               if (step) begin
                  if (phase_q == LAST_PH) begin
                     // wrap happens here only; the window then waits in LOAD for a new sample
                     phase_d = '0;
                     last_d  = 1'b0;
                     valid_d = 1'b0;
                     state_d = ST_LOAD;
                  end else begin
                     phase_d = phase_q + PW'(1);
                     last_d  = ((phase_q + PW'(1)) == LAST_PH);
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  x2_d    = x1_q;
                  x1_d    = x0_q;
                  x0_d    = bus.data_i;
                  phase_d = '0;
                  last_d  = 1'b0;
                  valid_d = 1'b1;
                  state_d = ST_EMIT;
               end
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase
      end
   end

   // state and output registers, asynchronously reset to the same image as clear
   always_ff @(posedge clk or posedge rsth) begin
      if (rsth) begin
         state_q    <= ST_FILL;
         fill_cnt_q <= 2'd0;
         x0_q       <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         phase_q    <= '0;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
         primed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         x0_q       <= x0_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         phase_q    <= phase_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         primed_q   <= primed_d;
      end
   end

   assign bus.ready_o  = ready;
   assign bus.x0_o     = x0_q;
   assign bus.x1_o     = x1_q;
   assign bus.x2_o     = x2_q;
   assign bus.phase_o  = phase_q;
   assign bus.last_o   = last_q;
   assign bus.valid_o  = valid_q;
   assign bus.primed_o = primed_q;
endmodule

// File: tb/tb_poly2_sample_window.sv
// tb/tb_poly2_sample_window.sv - directed vector bench for poly2_sample_window
module tb_poly2_sample_window;
   logic clk;
   logic rst;
   logic clr;

   int errors;
   int checks;

   poly2_sample_window_if #(.DATA_WIDTH(16), .PHASES(4)) bus ();
   poly2_sample_window_if #(.DATA_WIDTH(16), .PHASES(2)) bus2 ();

   poly2_sample_window #(.DATA_WIDTH(16), .PHASES(4)) dut (
      .clk  (clk),
      .rsth (rst),
      .clrh (clr),
      .bus  (bus.slave)
   );

   poly2_sample_window #(.DATA_WIDTH(16), .PHASES(2)) dut2 (
      .clk  (clk),
      .rsth (rst),
      .clrh (clr),
      .bus  (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        vi;
      logic [15:0] d;
      logic        ri;
      logic        ev;
      logic [15:0] x0;
      logic [15:0] x1;
      logic [15:0] x2;
      logic [1:0]  ph;
      logic        last;
      logic        primed;
      logic        ro;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic c, logic vi, logic [15:0] d, logic ri, logic ev,
                               logic [15:0] x0, logic [15:0] x1, logic [15:0] x2,
                               logic [1:0] ph, logic last, logic primed, logic ro);
      vec_t v;
      v.clr = c; v.vi = vi; v.d = d; v.ri = ri; v.ev = ev;
      v.x0 = x0; v.x1 = x1; v.x2 = x2; v.ph = ph; v.last = last;
      v.primed = primed; v.ro = ro;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input vec_t v);
      check({tag, " valid_o"},  {31'd0, bus.valid_o},  {31'd0, v.ev});
      check({tag, " x0_o"},     {16'd0, bus.x0_o},     {16'd0, v.x0});
      check({tag, " x1_o"},     {16'd0, bus.x1_o},     {16'd0, v.x1});
      check({tag, " x2_o"},     {16'd0, bus.x2_o},     {16'd0, v.x2});
      check({tag, " phase_o"},  {30'd0, bus.phase_o},  {30'd0, v.ph});
      check({tag, " last_o"},   {31'd0, bus.last_o},   {31'd0, v.last});
      check({tag, " primed_o"}, {31'd0, bus.primed_o}, {31'd0, v.primed});
      check({tag, " ready_o"},  {31'd0, bus.ready_o},  {31'd0, v.ro});
   endtask

   task automatic drive(input logic c, input logic vi, input logic [15:0] d, input logic ri);
      clr         = c;
      bus.valid_i = vi;
      bus.data_i  = d;
      bus.ready_i = ri;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int bubbles;

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      clr = 1'b0;
      bus.valid_i = 1'b0; bus.data_i = '0; bus.ready_i = 1'b0;
      bus2.valid_i = 1'b0; bus2.data_i = '0; bus2.ready_i = 1'b0;

      //          clr vi data     ri | ev x0       x1       x2       ph last pr ro
      vecs[0]  = mk(0, 1, 16'd10,  1,  0, 16'd10,  16'd0,   16'd0,   0, 0, 0, 1);
      vecs[1]  = mk(0, 1, 16'd20,  1,  0, 16'd20,  16'd10,  16'd0,   0, 0, 0, 1);
      vecs[2]  = mk(0, 1, 16'd30,  1,  1, 16'd30,  16'd20,  16'd10,  0, 0, 1, 0);
      vecs[3]  = mk(0, 1, 16'd99,  1,  1, 16'd30,  16'd20,  16'd10,  1, 0, 1, 0);
      vecs[4]  = mk(0, 0, 16'd0,   1,  1, 16'd30,  16'd20,  16'd10,  2, 0, 1, 0);
      vecs[5]  = mk(0, 0, 16'd0,   1,  1, 16'd30,  16'd20,  16'd10,  3, 1, 1, 0);
      vecs[6]  = mk(0, 0, 16'd0,   1,  0, 16'd30,  16'd20,  16'd10,  0, 0, 1, 1);
      vecs[7]  = mk(0, 1, 16'd40,  1,  1, 16'd40,  16'd30,  16'd20,  0, 0, 1, 0);
      vecs[8]  = mk(0, 0, 16'd0,   1,  1, 16'd40,  16'd30,  16'd20,  1, 0, 1, 0);
      vecs[9]  = mk(0, 0, 16'd0,   1,  1, 16'd40,  16'd30,  16'd20,  2, 0, 1, 0);
      vecs[10] = mk(0, 1, 16'd77,  0,  1, 16'd40,  16'd30,  16'd20,  2, 0, 1, 0);
      vecs[11] = mk(0, 0, 16'd0,   0,  1, 16'd40,  16'd30,  16'd20,  2, 0, 1, 0);
      vecs[12] = mk(0, 0, 16'd0,   0,  1, 16'd40,  16'd30,  16'd20,  2, 0, 1, 0);
      vecs[13] = mk(0, 0, 16'd0,   1,  1, 16'd40,  16'd30,  16'd20,  3, 1, 1, 0);
      vecs[14] = mk(0, 0, 16'd0,   1,  0, 16'd40,  16'd30,  16'd20,  0, 0, 1, 1);
      vecs[15] = mk(0, 0, 16'd0,   1,  0, 16'd40,  16'd30,  16'd20,  0, 0, 1, 1);
      vecs[16] = mk(1, 1, 16'd55,  1,  0, 16'd0,   16'd0,   16'd0,   0, 0, 0, 1);
      vecs[17] = mk(0, 1, 16'h8000,1,  0, 16'h8000,16'd0,   16'd0,   0, 0, 0, 1);
      vecs[18] = mk(0, 1, 16'h7FFF,1,  0, 16'h7FFF,16'h8000,16'd0,   0, 0, 0, 1);
      vecs[19] = mk(0, 1, 16'hFFFF,1,  1, 16'hFFFF,16'h7FFF,16'h8000,0, 0, 1, 0);
      vecs[20] = mk(0, 0, 16'd0,   1,  1, 16'hFFFF,16'h7FFF,16'h8000,1, 0, 1, 0);
      vecs[21] = mk(0, 0, 16'd0,   1,  1, 16'hFFFF,16'h7FFF,16'h8000,2, 0, 1, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].clr, vecs[i].vi, vecs[i].d, vecs[i].ri);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i]);
      end

      // asynchronous reset mid-EMIT (phase 2), seen before any clock edge
      drive(0, 0, 16'd0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();
      rst = 1'b0;

      // refill needs three fresh samples
      drive(0, 1, 16'd1, 1); tick();
      drive(0, 1, 16'd2, 1); tick();
      check("refill_not_valid_after_2", {31'd0, bus.valid_o}, 32'd0);
      drive(0, 1, 16'd3, 1); tick();
      check_all("refill", mk(0, 0, 0, 0, 1, 16'd3, 16'd2, 16'd1, 0, 0, 1, 0));

      // saturated stream: 10 edges contain exactly two LOAD bubbles
      bubbles = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 16'(100 + i), 1);
         tick();
         if (!bus.valid_o) bubbles++;
      end
      check("stream_bubbles", bubbles, 32'd2);
      check("stream_x0", {16'd0, bus.x0_o}, 32'd109);
      check("stream_x1", {16'd0, bus.x1_o}, 32'd104);
      check("stream_phase", {30'd0, bus.phase_o}, 32'd0);
      drive(0, 0, 16'd0, 0);

      // PHASES=2 instance: phases 0,1 only, then LOAD
      bus2.ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus2.valid_i = 1'b1;
         bus2.data_i  = 16'(i);
         tick();
      end
      bus2.valid_i = 1'b0;
      check("p2_valid0", {31'd0, bus2.valid_o}, 32'd1);
      check("p2_phase0", {31'd0, bus2.phase_o}, 32'd0);
      check("p2_last0",  {31'd0, bus2.last_o},  32'd0);
      bus2.ready_i = 1'b1;
      tick();
      check("p2_phase1", {31'd0, bus2.phase_o}, 32'd1);
      check("p2_last1",  {31'd0, bus2.last_o},  32'd1);
      check("p2_valid1", {31'd0, bus2.valid_o}, 32'd1);
      tick();
      check("p2_load_valid", {31'd0, bus2.valid_o}, 32'd0);
      check("p2_load_phase", {31'd0, bus2.phase_o}, 32'd0);
      check("p2_load_ready", {31'd0, bus2.ready_o}, 32'd1);
      check("p2_x0", {16'd0, bus2.x0_o}, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
